// File: rtl/fb_writer.sv
// fb_writer: draws pixels, horizontal lines and (optionally) full-screen clears into a
// framebuffer built from four 16K x 1 RAM banks.
//
// Commands are accepted in IDLE, decoded and address-translated in CALC, then written one
// pixel per cycle in WRITE. Addresses are linear (y * WIDTH + x); the two top bits of the
// 16-bit linear address select the bank and the low 14 bits address within it.
//
// Build option: define FB_WRITER_CLEAR_EN to enable the clear-screen op (10). Without it,
// op 10 is rejected like the reserved op and the wide clear counter is not built.
//
// Ports:
//   clk        clock, all logic on rising edge
//   reset      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  high in IDLE only
//   cmd_op     00 pixel, 01 hline, 10 clear, 11 reserved
//   cmd_x      start column
//   cmd_y      row
//   cmd_len    hline length in pixels
//   cmd_color  pixel value
//   ram_we     one-hot bank write strobe
//   ram_addr   bank-local address
//   ram_data   write data
//   busy       high whenever not IDLE
//   err        one-cycle pulse (during CALC) for a rejected command
module fb_writer #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [8:0]  cmd_len,
    input  logic        cmd_color,
    output logic [3:0]  ram_we,
    output logic [13:0] ram_addr,
    output logic        ram_data,
    output logic        busy,
    output logic        err
);

`ifdef FB_WRITER_CLEAR_EN
    // Must hold WIDTH * HEIGHT for a full clear.
    localparam int unsigned CntW = 16;
`else
    // Longest hline is limited by the 9-bit length field.
    localparam int unsigned CntW = 9;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StWrite} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [8:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [8:0]        len_q, len_d;
    logic              color_q, color_d;
    logic [15:0]       lin_q, lin_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [15:0]       linear;
    logic [9:0]        room;
    logic [8:0]        hcount;
    logic              coord_bad;

    assign linear    = 16'(32'(y_q) * WIDTH + 32'(x_q));
    // Pixels left on the row from x to the right edge; clips lines instead of wrapping.
    assign room      = 10'(WIDTH - 32'(x_q));
    assign hcount    = ({1'b0, len_q} < room) ? len_q : room[8:0];
    assign coord_bad = (32'(x_q) >= WIDTH) || (32'(y_q) >= HEIGHT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            x_q     <= '0;
            y_q     <= '0;
            len_q   <= '0;
            color_q <= 1'b0;
            lin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            len_q   <= len_d;
            color_q <= color_d;
            lin_q   <= lin_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        len_d     = len_q;
        color_d   = color_q;
        lin_d     = lin_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_data  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    len_d   = cmd_len;
                    color_d = cmd_color;
                    state_d = StCalc;
                end
            end

            StCalc: begin
                state_d = StIdle;
                unique case (op_q)
                    2'b00: begin
                        if (coord_bad) begin
                            err = 1'b1;
                        end else begin
                            lin_d   = linear;
                            cnt_d   = CntW'(1);
                            state_d = StWrite;
                        end
                    end
                    2'b01: begin
                        if (coord_bad) begin
                            err = 1'b1;
                        end else if (hcount != 9'd0) begin
                            lin_d   = linear;
                            cnt_d   = CntW'(hcount);
                            state_d = StWrite;
                        end
                    end
                    2'b10: begin
`ifdef FB_WRITER_CLEAR_EN
                        lin_d   = '0;
                        cnt_d   = CntW'(WIDTH * HEIGHT);
                        state_d = StWrite;
`else
                        err = 1'b1;
`endif
                    end
                    default: err = 1'b1;
                endcase
            end

            StWrite: begin
                ram_we   = 4'b0001 << lin_q[15:14];
                ram_addr = lin_q[13:0];
                ram_data = color_q;
                // Linear increment carries addr 16383 -> 0 into the next bank.
                lin_d    = lin_q + 16'd1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter WIDTH, default 320, framebuffer width in pixels.
REQ-002 Parameter HEIGHT, default 200, framebuffer height in pixels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  00 pixel, 01 horizontal line, 10 clear screen, 11 reserved.
REQ-008 cmd_x  input  9  start column.
REQ-009 cmd_y  input  8  row.
REQ-010 cmd_len  input  9  line length in pixels (hline only).
REQ-011 cmd_color  input  1  pixel value to write.
REQ-012 ram_we  output  4  one-hot write strobe, one bit per 16K x 1 bank.
REQ-013 ram_addr  output  14  bank-local write address.
REQ-014 ram_data  output  1  write data.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 err  output  1  one-cycle pulse on a rejected command.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; all cmd_* fields SHALL be latched at that edge.
REQ-018 cmd_ready SHALL be 1 only in IDLE; later changes to cmd_* SHALL not affect an accepted command.
REQ-019 States SHALL be IDLE, CALC, WRITE: IDLE->CALC on accept; CALC->WRITE for a valid command; CALC->IDLE with an err pulse for a rejected command; WRITE->IDLE after the last write.
REQ-020 CALC SHALL compute linear = y*WIDTH + x as 16 bits; bank = linear[15:14]; ram_addr = linear[13:0].
REQ-021 Latency: for an accept at edge N, the first ram_we pulse SHALL be asserted during cycle N+2; cmd_ready SHALL return to 1 in the cycle after the last write.
REQ-022 Pixel: exactly one write cycle.
REQ-023 Hline: one write per cycle at consecutive columns, count = min(len, WIDTH - x); writes SHALL clip at column WIDTH-1 and never wrap to the next row.
REQ-024 Address increment SHALL carry from ram_addr 16383 to 0 with the bank advancing by one.
REQ-025 Hline with len = 0 SHALL perform no writes, raise no err, and return to IDLE after CALC.
REQ-026 Rejected commands (x >= WIDTH, y >= HEIGHT, op 11, or op 10 when clear is compiled out) SHALL produce no write and a single err pulse during CALC.
REQ-027 ram_we SHALL be 0000 in every cycle outside WRITE; exactly one bit SHALL be set in each WRITE cycle.
REQ-028 ram_data SHALL equal the latched color during WRITE and 0 otherwise.

Reset
REQ-029 While reset = 0 at an edge, the block SHALL enter IDLE with cmd_ready = 1, busy = 0, err = 0, ram_we = 0000, ram_addr = 0, and ram_data = 0.
REQ-030 A reset during WRITE SHALL abort the command, and no ram_we pulse SHALL occur in the cycle after reset is sampled.

Configuration
REQ-031 Macro FB_WRITER_CLEAR_EN: when defined, op 10 SHALL write cmd_color to linear addresses 0..WIDTH*HEIGHT-1, one per cycle (64000 writes at default size), ignoring x, y and len.
REQ-032 When FB_WRITER_CLEAR_EN is undefined, op 10 SHALL be rejected per REQ-026 and the clear-counter logic SHALL be absent.

Verification
REQ-033 Pixel (0,0), color 1, accepted at edge N -> in cycle N+2: ram_we = 0001, ram_addr = 0, ram_data = 1 for one cycle; cmd_ready = 1 at N+3.
REQ-034 Pixel (319,199) -> linear 63999: ram_we = 1000, ram_addr = 0x39FF.
REQ-035 Hline x = 60, y = 51 (linear 16380), len 8 -> bank 0 writes at 16380..16383, then bank 1 writes at 0..3; 8 writes on consecutive cycles.
REQ-036 Hline x = 315, y = 10, len 10 -> exactly 5 writes (columns 315..319); cmd_x = 320 -> one err pulse and zero writes.
REQ-037 Clear with color 0, macro defined -> 64000 write cycles, busy high throughout; macro undefined -> err pulse, no writes.
REQ-038 reset = 0 on the 3rd write cycle of an hline of len 20 -> no further ram_we; IDLE with cmd_ready = 1 on the next cycle.
